// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MIPS mult/div unit with HI/LO registers and a pipeline stall request
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, mul_nxt, div_nxt, prod;
    logic [WIDTH-1:0] opb, abs_a, abs_b, nrem, quo, rem;
    logic [WIDTH:0] sum, trial, diff;
    logic is_div, neg_q, neg_r, is_md, op_div, op_sgn, div0, last;

    always_comb begin
        op_div = (op == 3'd3) || (op == 3'd4);
        op_sgn = (op == 3'd1) || (op == 3'd3);
        is_md = start && (op != 3'd0) && (op <= 3'd4);
        div0 = op_div && (b == '0);
        abs_a = (op_sgn && a[WIDTH-1]) ? -a : a;
        abs_b = (op_sgn && b[WIDTH-1]) ? -b : b;
        last = cnt == CW'(WIDTH - 1);
        // acc = {upper partial product, remaining multiplier} or {remainder, dividend/quotient}
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt = {sum, acc[WIDTH-1:1]};
        trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = trial - {1'b0, opb};
        nrem = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        div_nxt = {nrem, acc[WIDTH-2:0], ~diff[WIDTH]};
        prod = neg_q ? -mul_nxt : mul_nxt;
        quo = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
        rem = neg_r ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
        stall_req = !flush && ((state == RUN) || (state == IDLE && is_md));
        state_d = flush ? IDLE :
                  state == IDLE ? (is_md ? (div0 ? DONE : RUN) : IDLE) :
                  state == RUN ? (last ? DONE : RUN) : IDLE;
    end

    assign busy = state == RUN;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            opb <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            state <= state_d;
            if (!flush && state == IDLE) begin
                if (is_md) begin
                    acc <= {{WIDTH{1'b0}}, abs_a};
                    opb <= abs_b;
                    cnt <= '0;
                    is_div <= op_div;
                    neg_q <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r <= op_sgn && a[WIDTH-1];
                    if (div0) begin
                        hi <= a;
                        lo <= '1;
                    end
                end else if (start && op == 3'd5) begin
                    hi <= a;
                end else if (start && op == 3'd6) begin
                    lo <= a;
                end
            end
            if (!flush && state == RUN) begin
                acc <= is_div ? div_nxt : mul_nxt;
                cnt <= cnt + CW'(1);
                if (last) begin
                    hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
                    lo <= is_div ? quo : prod[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed checks of ex_muldiv_unit against a 64-bit arithmetic model
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst, start, flush;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    logic stall_req, busy, done;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            3'd1: res = sx * sy;
            3'd2: res = {32'b0, x} * {32'b0, y};
            3'd3: if (y == 0) res = {x, 32'hFFFFFFFF};
                  else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
            3'd4: if (y == 0) res = {x, 32'hFFFFFFFF};
                  else res = {x % y, x / y};
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int stalls, output int busys, output logic done_ok, output logic done_drop);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        #1;
        stalls = 0;
        busys = 0;
        while (stall_req && stalls < 100) begin
            stalls++;
            if (busy) busys++;
            @(posedge clk); #2;
        end
        done_ok = done;
        start = 1'b0; op = 3'd0;
        @(posedge clk); #1;
        done_drop = ~done;
    endtask

    task automatic write_reg(input logic [2:0] o, input logic [31:0] x);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
        total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (stall_req !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_req); else passed++;
        rst = 1'b0;
    endtask

    task automatic check_table(input string name, input logic [2:0] ops[4], input logic [31:0] xs[4], input logic [31:0] ys[4]);
        int st, bs;
        logic dk, dd;
        logic [63:0] e;
        for (int i = 0; i < 4; i++) begin
            e = model(ops[i], xs[i], ys[i]);
            run_op(ops[i], xs[i], ys[i], st, bs, dk, dd);
            total++; if (st != 33) $display("FAIL %s[%0d]_stall_cycles got %0d want 33", name, i, st); else passed++;
            total++; if (bs != 32) $display("FAIL %s[%0d]_busy_cycles got %0d want 32", name, i, bs); else passed++;
            total++; if (dk !== 1'b1 || dd !== 1'b1) $display("FAIL %s[%0d]_done_pulse got %b%b want 11", name, i, dk, dd); else passed++;
            total++; if (hi !== e[63:32]) $display("FAIL %s[%0d]_hi got %h want %h", name, i, hi, e[63:32]); else passed++;
            total++; if (lo !== e[31:0]) $display("FAIL %s[%0d]_lo got %h want %h", name, i, lo, e[31:0]); else passed++;
        end
    endtask

    task automatic test_mul();
        logic [2:0] ops[4] = '{3'd2, 3'd1, 3'd1, 3'd2};
        logic [31:0] xs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h00012345};
        logic [31:0] ys[4] = '{32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'h0};
        check_table("mul", ops, xs, ys);
        total++; if ({hi, lo} !== 64'h0) $display("FAIL mul_zero got %h want 0", {hi, lo}); else passed++;
    endtask

    task automatic test_div();
        logic [2:0] ops[4] = '{3'd3, 3'd4, 3'd3, 3'd3};
        logic [31:0] xs[4] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7};
        logic [31:0] ys[4] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE};
        check_table("div", ops, xs, ys);
    endtask

    task automatic test_div0();
        int st, bs;
        logic dk, dd;
        logic [2:0] ops[2] = '{3'd4, 3'd3};
        logic [31:0] xs[2] = '{32'd5, 32'h80000001};
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], xs[i], 32'h0, st, bs, dk, dd);
            total++; if (st != 1) $display("FAIL div0[%0d]_stall_cycles got %0d want 1", i, st); else passed++;
            total++; if (bs != 0) $display("FAIL div0[%0d]_busy_cycles got %0d want 0", i, bs); else passed++;
            total++; if (dk !== 1'b1 || dd !== 1'b1) $display("FAIL div0[%0d]_done_pulse got %b%b want 11", i, dk, dd); else passed++;
            total++; if (hi !== xs[i]) $display("FAIL div0[%0d]_hi got %h want %h", i, hi, xs[i]); else passed++;
            total++; if (lo !== 32'hFFFFFFFF) $display("FAIL div0[%0d]_lo got %h want ffffffff", i, lo); else passed++;
        end
    endtask

    task automatic test_flush();
        logic seen;
        write_reg(3'd5, 32'hAAAA5555);
        write_reg(3'd6, 32'h0F0F0F0F);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; a = 32'h1234; b = 32'hFFFF0000;
        repeat (10) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("FAIL flush_busy_before got %b want 1", busy); else passed++;
        flush = 1'b1; start = 1'b0; op = 3'd0;
        #1;
        total++; if (stall_req !== 1'b0) $display("FAIL flush_stall got %b want 0", stall_req); else passed++;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy_after got %b want 0", busy); else passed++;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL flush_no_done got %b want 0", seen); else passed++;
        total++; if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F) $display("FAIL flush_hilo got %h_%h want aaaa5555_0f0f0f0f", hi, lo); else passed++;
        start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd0; flush = 1'b1;
        #1;
        total++; if (stall_req !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", stall_req); else passed++;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; flush = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_idle_state got busy=%b done=%b want 0 0", busy, done); else passed++;
        total++; if (hi !== 32'hAAAA5555) $display("FAIL flush_idle_hi got %h want aaaa5555", hi); else passed++;
    endtask

    task automatic test_mthi_mtlo();
        @(posedge clk); #1;
        start = 1'b1; op = 3'd5; a = 32'h12345678;
        #1;
        total++; if (stall_req !== 1'b0) $display("FAIL mthi_stall got %b want 0", stall_req); else passed++;
        @(posedge clk); #1;
        total++; if (hi !== 32'h12345678) $display("FAIL mthi_hi got %h want 12345678", hi); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi_state got busy=%b done=%b want 0 0", busy, done); else passed++;
        op = 3'd6; a = 32'h9ABCDEF0;
        #1;
        total++; if (stall_req !== 1'b0) $display("FAIL mtlo_stall got %b want 0", stall_req); else passed++;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        total++; if (lo !== 32'h9ABCDEF0) $display("FAIL mtlo_lo got %h want 9abcdef0", lo); else passed++;
        total++; if (hi !== 32'h12345678) $display("FAIL mtlo_hi_kept got %h want 12345678", hi); else passed++;
    endtask

    task automatic test_rst_mid_run();
        @(posedge clk); #1;
        start = 1'b1; op = 3'd2; a = 32'hDEADBEEF; b = 32'h1234;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0;
        total++; if (busy !== 1'b1) $display("FAIL rst_run_busy got %b want 1", busy); else passed++;
        rst = 1'b1;
        #1;
        total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL rst_run_hilo got %h_%h want 0_0", hi, lo); else passed++;
        total++; if (busy !== 1'b0 || stall_req !== 1'b0) $display("FAIL rst_run_idle got busy=%b stall=%b want 0 0", busy, stall_req); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int st, bs;
        logic dk, dd;
        logic [2:0] o;
        logic [31:0] x, y, eh, el;
        logic [63:0] e;
        eh = hi;
        el = lo;
        for (int i = 0; i < 25; i++) begin
            o = 3'($urandom_range(1, 6));
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (o == 3'd5) begin
                write_reg(o, x); eh = x;
            end else if (o == 3'd6) begin
                write_reg(o, x); el = x;
            end else begin
                e = model(o, x, y);
                eh = e[63:32];
                el = e[31:0];
                run_op(o, x, y, st, bs, dk, dd);
                total++;
                if (st != ((o >= 3'd3 && y == 0) ? 1 : 33) || dk !== 1'b1 || dd !== 1'b1)
                    $display("FAIL rand[%0d]_timing op=%0d stalls=%0d done=%b%b", i, o, st, dk, dd);
                else passed++;
            end
            total++;
            if (hi !== eh || lo !== el)
                $display("FAIL rand[%0d]_hilo op=%0d a=%h b=%h got %h_%h want %h_%h", i, o, x, y, hi, lo, eh, el);
            else passed++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_flush();
        test_mthi_mtlo();
        test_rst_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
